// File: rtl/prince_sbox_layer_ctrl_if.sv
// Bundle of the request/response and S-box side signals of the PRINCE
// S-box layer controller. The slave side is the controller itself; the
// master side is its environment (requester plus the S-box instance).
interface prince_sbox_layer_ctrl_if;
    logic        start_i;
    logic [63:0] state1_i;
    logic [63:0] state2_i;
    logic [63:0] state3_i;
    logic        busy_o;
    logic        done_o;
    logic [63:0] state1_o;
    logic [63:0] state2_o;
    logic [63:0] state3_o;
    logic [3:0]  sb_in1_o;
    logic [3:0]  sb_in2_o;
    logic [3:0]  sb_in3_o;
    logic [3:0]  sb_out1_i;
    logic [3:0]  sb_out2_i;
    logic [3:0]  sb_out3_i;
    logic        rnd_en_o;

    modport master (
        output start_i, state1_i, state2_i, state3_i,
        output sb_out1_i, sb_out2_i, sb_out3_i,
        input  busy_o, done_o, state1_o, state2_o, state3_o,
        input  sb_in1_o, sb_in2_o, sb_in3_o, rnd_en_o
    );

    modport slave (
        input  start_i, state1_i, state2_i, state3_i,
        input  sb_out1_i, sb_out2_i, sb_out3_i,
        output busy_o, done_o, state1_o, state2_o, state3_o,
        output sb_in1_o, sb_in2_o, sb_in3_o, rnd_en_o
    );
endinterface

// File: rtl/prince_sbox_layer_ctrl.sv
// Serialising controller for the PRINCE S-box layer on a 3-share masked
// 64-bit state. Nibbles of each share are streamed into one pipelined
// masked S-box, tracked by a token pipe, and reassembled per share.
// The three shares travel in fully separate registers end to end.
module prince_sbox_layer_ctrl #(
    parameter int unsigned SBOX_LAT = 6
) (
    input logic                    clk,
    input logic                    rst_i,
    prince_sbox_layer_ctrl_if.slave bus
);

    localparam int LAT = int'(SBOX_LAT);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FEED  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t          state_r;
    state_t          state_next_s;
    logic [3:0]      feed_cnt_r;
    logic [3:0]      cap_cnt_r;
    logic [63:0]     sh1_r, sh2_r, sh3_r;
    logic [63:0]     wk1_r, wk2_r, wk3_r;
    logic [63:0]     wk1_cap_s, wk2_cap_s, wk3_cap_s;
    logic [63:0]     out1_r, out2_r, out3_r;
    logic [3:0]      sb_in1_r, sb_in2_r, sb_in3_r;
    logic            sb_vld_r;
    logic [LAT-1:0]  tok_r;
    logic [LAT-1:0]  tok_next_s;
    logic            busy_r, done_r, rnd_en_r;
    logic            accept_s, feed_more_s, capture_s, cap_last_s;
    logic            vld_next_s, rnd_next_s;

    // Next-state, token-pipe shift and per-share capture merge.
    always_comb begin
        accept_s    = bus.start_i && ((state_r == ST_IDLE) || (state_r == ST_DONE));
        feed_more_s = (state_r == ST_FEED) && (feed_cnt_r != 4'd15);
        capture_s   = tok_r[LAT-1];
        cap_last_s  = capture_s && (cap_cnt_r == 4'd15);
        // sb_in holds a live nibble in the cycle after it is loaded; the
        // token enters the pipe one edge later so it exits with the result.
        vld_next_s  = accept_s || feed_more_s;

        tok_next_s    = {LAT{1'b0}};
        tok_next_s[0] = sb_vld_r;
        for (int i = 1; i < LAT; i++) begin
            tok_next_s[i] = tok_r[i-1];
        end

        state_next_s = state_r;
        case (state_r)
            ST_IDLE:  state_next_s = accept_s ? ST_FEED : ST_IDLE;
            ST_FEED:  state_next_s = (feed_cnt_r == 4'd15) ? ST_DRAIN : ST_FEED;
            ST_DRAIN: state_next_s = cap_last_s ? ST_DONE : ST_DRAIN;
            ST_DONE:  state_next_s = accept_s ? ST_FEED : ST_IDLE;
            default:  state_next_s = ST_IDLE;
        endcase

        rnd_next_s = (state_next_s == ST_FEED) || vld_next_s || (tok_next_s != {LAT{1'b0}});

        wk1_cap_s = wk1_r;
        wk2_cap_s = wk2_r;
        wk3_cap_s = wk3_r;
        wk1_cap_s[{cap_cnt_r, 2'b00} +: 4] = bus.sb_out1_i;
        wk2_cap_s[{cap_cnt_r, 2'b00} +: 4] = bus.sb_out2_i;
        wk3_cap_s[{cap_cnt_r, 2'b00} +: 4] = bus.sb_out3_i;
    end

    // FSM, counters, token pipe and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst_i) begin
            state_r    <= ST_IDLE;
            feed_cnt_r <= 4'd0;
            cap_cnt_r  <= 4'd0;
            sh1_r      <= 64'h0;
            sh2_r      <= 64'h0;
            sh3_r      <= 64'h0;
            wk1_r      <= 64'h0;
            wk2_r      <= 64'h0;
            wk3_r      <= 64'h0;
            out1_r     <= 64'h0;
            out2_r     <= 64'h0;
            out3_r     <= 64'h0;
            sb_in1_r   <= 4'h0;
            sb_in2_r   <= 4'h0;
            sb_in3_r   <= 4'h0;
            sb_vld_r   <= 1'b0;
            tok_r      <= {LAT{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            rnd_en_r   <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            busy_r   <= (state_next_s == ST_FEED) || (state_next_s == ST_DRAIN);
            done_r   <= cap_last_s;
            rnd_en_r <= rnd_next_s;
            sb_vld_r <= vld_next_s;
            tok_r    <= tok_next_s;

            // Nibble 0 goes out on the accepting edge; the shift registers
            // keep the full share so nibble k+1 sits at [7:4] on FEED edge k.
            if (accept_s) begin
                sh1_r      <= bus.state1_i;
                sh2_r      <= bus.state2_i;
                sh3_r      <= bus.state3_i;
                sb_in1_r   <= bus.state1_i[3:0];
                sb_in2_r   <= bus.state2_i[3:0];
                sb_in3_r   <= bus.state3_i[3:0];
                feed_cnt_r <= 4'd0;
            end else if (state_r == ST_FEED) begin
                feed_cnt_r <= feed_cnt_r + 4'd1;
                if (feed_more_s) begin
                    sb_in1_r <= sh1_r[7:4];
                    sb_in2_r <= sh2_r[7:4];
                    sb_in3_r <= sh3_r[7:4];
                    sh1_r    <= {4'h0, sh1_r[63:4]};
                    sh2_r    <= {4'h0, sh2_r[63:4]};
                    sh3_r    <= {4'h0, sh3_r[63:4]};
                end else begin
                    sb_in1_r <= 4'h0;
                    sb_in2_r <= 4'h0;
                    sb_in3_r <= 4'h0;
                end
            end else begin
                sb_in1_r <= 4'h0;
                sb_in2_r <= 4'h0;
                sb_in3_r <= 4'h0;
            end

            if (accept_s) begin
                cap_cnt_r <= 4'd0;
            end else if (capture_s) begin
                cap_cnt_r <= cap_cnt_r + 4'd1;
                wk1_r     <= wk1_cap_s;
                wk2_r     <= wk2_cap_s;
                wk3_r     <= wk3_cap_s;
            end else begin
                cap_cnt_r <= cap_cnt_r;
            end

            // Published result changes only together with done_o.
            if (cap_last_s) begin
                out1_r <= wk1_cap_s;
                out2_r <= wk2_cap_s;
                out3_r <= wk3_cap_s;
            end else begin
                out1_r <= out1_r;
            end
        end
    end

    assign bus.busy_o   = busy_r;
    assign bus.done_o   = done_r;
    assign bus.rnd_en_o = rnd_en_r;
    assign bus.sb_in1_o = sb_in1_r;
    assign bus.sb_in2_o = sb_in2_r;
    assign bus.sb_in3_o = sb_in3_r;
    assign bus.state1_o = out1_r;
    assign bus.state2_o = out2_r;
    assign bus.state3_o = out3_r;

endmodule
